period_duty_meter: RTL and testbench

PERIOD_DUTY_METER -- requirements
Module: period_duty_meter

---
 rtl/period_duty_meter.sv | 116 +++++++++++
 tb/tb_period_duty_meter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/period_duty_meter.sv
// rtl/period_duty_meter.sv - measures period and high time of an asynchronous square wave in clk cycles
module period_duty_meter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_sig,
    input  logic         en,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] period_cnt,
    output logic         valid,
    output logic         half,
    output logic         chg,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    state_t       state;
    logic         sync1;
    logic         s;
    logic         s_d;
    logic [W-1:0] hcnt;
    logic [W-1:0] pcnt;
    logic         first_pub;
    logic         rise;
    logic [W:0]   hcnt_x2;
    logic [W:0]   pcnt_ext;

    assign rise     = s & ~s_d;
    assign hcnt_x2  = {hcnt, 1'b0};
    assign pcnt_ext = {1'b0, pcnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= in_sig;
            s     <= sync1;
            s_d   <= s;
        end
    end

    // first_pub forces chg on the first publish after leaving IDLE, even if the period repeats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            pcnt       <= '0;
            first_pub  <= 1'b1;
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            half       <= 1'b0;
            chg        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                hcnt      <= '0;
                pcnt      <= '0;
                ovf       <= 1'b0;
                first_pub <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= ARMED;
                        first_pub <= 1'b1;
                    end
                    ARMED: begin
                        if (rise) begin
                            hcnt  <= CNT_ONE;
                            pcnt  <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            high_cnt   <= hcnt;
                            period_cnt <= pcnt;
                            valid      <= 1'b1;
                            half       <= (hcnt_x2 == pcnt_ext);
                            chg        <= first_pub | (pcnt != period_cnt);
                            first_pub  <= 1'b0;
                            hcnt       <= CNT_ONE;
                            pcnt       <= CNT_ONE;
                        end else if (pcnt == CNT_MAX) begin
                            // Period too long to represent: drop it and wait for a fresh rise.
                            ovf   <= 1'b1;
                            hcnt  <= '0;
                            pcnt  <= '0;
                            state <= ARMED;
                        end else begin
                            pcnt <= pcnt + CNT_ONE;
                            if (s) begin
                                hcnt <= hcnt + CNT_ONE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_duty_meter.sv
// tb/tb_period_duty_meter.sv - directed self-checking bench for period_duty_meter
module tb_period_duty_meter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_sig = 1'b0;
    logic       en = 1'b0;
    logic [7:0] high_cnt;
    logic [7:0] period_cnt;
    logic       valid;
    logic       half;
    logic       chg;
    logic       ovf;

    period_duty_meter #(.W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_sig     (in_sig),
        .en         (en),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .valid      (valid),
        .half       (half),
        .chg        (chg),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] h;
        logic [7:0] p;
        logic       hf;
        logic       cg;
        logic       ov;
        int         cyc;
    } pub_t;

    pub_t obs[$];
    pub_t exp_q[$];
    int   rises[$];
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            pub_t r;
            r.h   = high_cnt;
            r.p   = period_cnt;
            r.hf  = half;
            r.cg  = chg;
            r.ov  = ovf;
            r.cyc = cyc;
            obs.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        if (v && !in_sig) rises.push_back(cyc + 1);
        in_sig = v;
    endtask

    task automatic hold(input int n, input logic v);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            hold(hi, 1'b1);
            hold(lo, 1'b0);
        end
    endtask

    task automatic exp_pub(input logic [7:0] h, input logic [7:0] p,
                           input logic hf, input logic cg, input logic ov);
        pub_t r;
        r.h = h; r.p = p; r.hf = hf; r.cg = cg; r.ov = ov; r.cyc = 0;
        exp_q.push_back(r);
    endtask

    task automatic compare_pubs(input string tag);
        check($sformatf("%s.count", tag), obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            int found = 0;
            check($sformatf("%s[%0d].high", tag, i), obs[i].h, exp_q[i].h);
            check($sformatf("%s[%0d].period", tag, i), obs[i].p, exp_q[i].p);
            check($sformatf("%s[%0d].half", tag, i), obs[i].hf, exp_q[i].hf);
            check($sformatf("%s[%0d].chg", tag, i), obs[i].cg, exp_q[i].cg);
            check($sformatf("%s[%0d].ovf", tag, i), obs[i].ov, exp_q[i].ov);
            foreach (rises[j]) if (rises[j] + 2 == obs[i].cyc) found = 1;
            check($sformatf("%s[%0d].latency", tag, i), found, 1);
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic check_outs(input string tag, input logic [7:0] h, input logic [7:0] p,
                              input logic v, input logic hf, input logic cg, input logic ov);
        check({tag, ".high"}, high_cnt, h);
        check({tag, ".period"}, period_cnt, p);
        check({tag, ".valid"}, valid, v);
        check({tag, ".half"}, half, hf);
        check({tag, ".chg"}, chg, cg);
        check({tag, ".ovf"}, ovf, ov);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outs("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        en = 1'b1;

        // divide-by-6, then 2/5, then the 2-cycle minimum period
        hold(4, 1'b0);
        wave(3, 3, 5);
        wave(2, 5, 3);
        wave(1, 1, 4);
        hold(6, 1'b0);
        exp_pub(8'd3, 8'd6, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) exp_pub(8'd3, 8'd6, 1'b1, 1'b0, 1'b0);
        exp_pub(8'd2, 8'd7, 1'b0, 1'b1, 1'b0);
        exp_pub(8'd2, 8'd7, 1'b0, 1'b0, 1'b0);
        exp_pub(8'd2, 8'd7, 1'b0, 1'b0, 1'b0);
        exp_pub(8'd1, 8'd2, 1'b1, 1'b1, 1'b0);
        exp_pub(8'd1, 8'd2, 1'b1, 1'b0, 1'b0);
        exp_pub(8'd1, 8'd2, 1'b1, 1'b0, 1'b0);
        compare_pubs("wave");

        @(negedge clk);
        en = 1'b0;
        hold(2, 1'b0);
        check_outs("en_off1", 8'd1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("en_off1.nopub", obs.size(), 0);

        // overflow: high for 300 cycles after the arming rise
        @(negedge clk);
        en = 1'b1;
        hold(3, 1'b0);
        hold(300, 1'b1);
        check("ovf.set", ovf, 1'b1);
        check("ovf.nopub", obs.size(), 0);
        hold(3, 1'b0);
        wave(2, 2, 3);
        hold(4, 1'b0);
        exp_pub(8'd2, 8'd4, 1'b1, 1'b1, 1'b1);
        exp_pub(8'd2, 8'd4, 1'b1, 1'b0, 1'b1);
        compare_pubs("after_ovf");

        // en dropped in the 4th cycle of a period
        wave(3, 3, 2);
        hold(3, 1'b1);
        @(negedge clk);
        en = 1'b0;
        in_sig = 1'b0;
        hold(2, 1'b0);
        exp_pub(8'd2, 8'd8, 1'b0, 1'b1, 1'b1);
        exp_pub(8'd3, 8'd6, 1'b1, 1'b1, 1'b1);
        exp_pub(8'd3, 8'd6, 1'b1, 1'b0, 1'b1);
        compare_pubs("pre_drop");
        check_outs("en_off2", 8'd3, 8'd6, 1'b0, 1'b1, 1'b0, 1'b0);

        // re-enable: partial period discarded, chg forced on the same period
        @(negedge clk);
        en = 1'b1;
        hold(3, 1'b0);
        wave(3, 3, 3);
        exp_pub(8'd3, 8'd6, 1'b1, 1'b1, 1'b0);
        exp_pub(8'd3, 8'd6, 1'b1, 1'b0, 1'b0);
        compare_pubs("reenable");

        // reset mid-period aborts the pending publish
        hold(2, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        in_sig = 1'b0;
        #1;
        check_outs("mid_reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_reset.nopub", obs.size(), 0);
        reset = 1'b0;
        hold(3, 1'b0);
        wave(2, 2, 3);
        hold(4, 1'b0);
        exp_pub(8'd2, 8'd4, 1'b1, 1'b1, 1'b0);
        exp_pub(8'd2, 8'd4, 1'b1, 1'b0, 1'b0);
        compare_pubs("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
